// File: rtl/multi_mode_register_if.sv
// Control/data bundle for multi_mode_register: operation selects, limits and step in,
// current value, direction and event pulses out.
interface multi_mode_register_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              load;
    logic              shr;
    logic              shl;
    logic              rot;
    logic              arith;
    logic              inc;
    logic              dec;
    logic              run;
    logic              loop;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  min;
    logic [WIDTH-1:0]  max;
    logic [WIDTH-1:0]  in;
    logic [WIDTH-1:0]  out;
    logic              dir;
    logic              at_max;
    logic              at_min;
    logic              wrapped;
    logic              saturated;

    modport master (
        output load, shr, shl, rot, arith, inc, dec, run, loop, step, min, max, in,
        input  out, dir, at_max, at_min, wrapped, saturated
    );

    modport slave (
        input  load, shr, shl, rot, arith, inc, dec, run, loop, step, min, max, in,
        output out, dir, at_max, at_min, wrapped, saturated
    );
endinterface

// File: rtl/multi_mode_register.sv
// Load/shift/count register with programmable step, limit-aware counting (wrap or
// saturate) and an autonomous up/down bounce mode driven by a two-state direction FSM.
module multi_mode_register #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input logic                   clk,
    input logic                   reset,
    multi_mode_register_if.slave  bus
);
    // One extra bit beyond the wider of value/step so sums never wrap silently.
    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_state_t;

    dir_state_t        state;
    logic [WIDTH-1:0]  value;
    logic              wrap_q;
    logic              sat_q;

    logic [CW-1:0]     sum_up;
    logic [CW-1:0]     span_down;
    logic [WIDTH-1:0]  diff_down;
    logic              can_up;
    logic              can_down;
    logic              limits_ok;
    logic              step_zero;
    logic              equal_limits;

    logic [31:0]       amt;
    logic [31:0]       amt_rot;
    logic [WIDTH-1:0]  rot_r;
    logic [WIDTH-1:0]  rot_l;
    logic [WIDTH-1:0]  shr_res;
    logic [WIDTH-1:0]  shl_res;

    always_comb begin
        sum_up       = CW'(value) + CW'(bus.step);
        span_down    = CW'(value) - CW'(bus.min);
        diff_down    = value - WIDTH'(bus.step);
        can_up       = sum_up <= CW'(bus.max);
        can_down     = (value >= bus.min) && (span_down >= CW'(bus.step));
        limits_ok    = bus.min <= bus.max;
        step_zero    = bus.step == '0;
        equal_limits = bus.min == bus.max;
    end

    // A zero rotate amount shifts the complementary half out by WIDTH, leaving value intact.
    always_comb begin
        amt     = 32'(bus.step);
        amt_rot = amt % WIDTH;
        rot_r   = (value >> amt_rot) | (value << (32'(WIDTH) - amt_rot));
        rot_l   = (value << amt_rot) | (value >> (32'(WIDTH) - amt_rot));
        if (bus.rot) begin
            shr_res = rot_r;
        end else if (bus.arith) begin
            shr_res = (amt >= 32'(WIDTH)) ? {WIDTH{value[WIDTH-1]}}
                                          : WIDTH'($signed(value) >>> amt);
        end else begin
            shr_res = (amt >= 32'(WIDTH)) ? '0 : (value >> amt);
        end
        if (bus.rot) begin
            shl_res = rot_l;
        end else begin
            shl_res = (amt >= 32'(WIDTH)) ? '0 : (value << amt);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value  <= '0;
            state  <= UP;
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            sat_q  <= 1'b0;
            if (bus.load) begin
                value <= bus.in;
            end else if (bus.shr) begin
                if (!step_zero) value <= shr_res;
            end else if (bus.shl) begin
                if (!step_zero) value <= shl_res;
            end else if (bus.inc) begin
                if (!step_zero && limits_ok) begin
                    if (can_up) begin
                        value <= sum_up[WIDTH-1:0];
                    end else if (bus.loop) begin
                        value  <= bus.min;
                        wrap_q <= 1'b1;
                    end else begin
                        value <= bus.max;
                        sat_q <= 1'b1;
                    end
                end
            end else if (bus.dec) begin
                if (!step_zero && limits_ok) begin
                    if (can_down) begin
                        value <= diff_down;
                    end else if (bus.loop) begin
                        value  <= bus.max;
                        wrap_q <= 1'b1;
                    end else begin
                        value <= bus.min;
                        sat_q <= 1'b1;
                    end
                end
            end else if (bus.run) begin
                // Bounce: turn around on landing at a limit, flag only genuine clipping.
                if (!step_zero && limits_ok) begin
                    if (equal_limits) begin
                        value <= bus.min;
                        state <= (state == UP) ? DOWN : UP;
                    end else if (state == UP) begin
                        if (can_up) begin
                            value <= sum_up[WIDTH-1:0];
                            if (sum_up[WIDTH-1:0] == bus.max) state <= DOWN;
                        end else begin
                            value <= bus.max;
                            sat_q <= 1'b1;
                            state <= DOWN;
                        end
                    end else begin
                        if (can_down) begin
                            value <= diff_down;
                            if (diff_down == bus.min) state <= UP;
                        end else begin
                            value <= bus.min;
                            sat_q <= 1'b1;
                            state <= UP;
                        end
                    end
                end
            end
        end
    end

    assign bus.out       = value;
    assign bus.dir       = (state == DOWN);
    assign bus.wrapped   = wrap_q;
    assign bus.saturated = sat_q;
    assign bus.at_max    = (value == bus.max);
    assign bus.at_min    = (value == bus.min);
endmodule
